dma_copy: RTL and testbench
===========================

// Module: dma_copy
// PURPOSE
//  Bus initiator: word-copy engine that drives the CPU-side native memory bus (valid/ready,
//  addr/wdata/wstrb/rdata) as a second master. Copies LENGTH words SRC->DST, one read then one
//  write per word. Sits behind the bus arbiter next to the CPU. Programmed as an MMIO core via
//  the standard cs/we/address/write_data/read_data/ready target interface.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  max cycles mem_valid may wait for mem_ready before error abort
//  LEN_WIDTH       16    width of LENGTH/REMAINING word counters
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous active-low reset
//  cs          in   1   target select (MMIO)
//  we          in   1   target write enable
//  address     in   8   target word address
//  write_data  in   32  target write data
//  read_data   out  32  target read data, combinational, 0 when cs low
//  ready       out  1   target ready, combinational = cs (zero wait)
//  mem_valid   out  1   initiator request valid
//  mem_addr    out  32  initiator byte address, bits [1:0] always 0
//  mem_wdata   out  32  initiator write data
//  mem_wstrb   out  4   initiator byte strobes, 4'h0 = read, 4'hf = write
//  mem_ready   in   1   initiator transaction complete
//  mem_rdata   in   32  initiator read data, valid when mem_ready
//  busy        out  1   copy in progress (arbiter request)
// BEHAVIOUR
//  Clock/reset: one clock (clk); reset_n asynchronous, active-low. Reset: all outputs 0,
//   FSM IDLE, all registers 0.
//  Registers (word addr): 0x08 CTRL (W: bit0 start, bit1 abort); 0x09 STATUS (R: bit0 busy,
//   bit1 done, bit2 error, bit3 aborted); 0x10 SRC; 0x11 DST; 0x12 LENGTH; 0x13 REMAINING (R).
//   SRC/DST/LENGTH writes ignored while busy; SRC/DST [1:0] forced 0; reads show live progress.
//   Unmapped reads return 0.
//  FSM: IDLE -> READ -> WRITE -> (READ | IDLE).
//   IDLE: start with LENGTH!=0: clear done/error/aborted, REMAINING<=LENGTH, busy=1, go READ
//    next cycle. Start with LENGTH==0: done=1 next cycle, no bus traffic. Start while busy:
//    ignored.
//   READ: mem_valid=1, mem_addr=SRC, mem_wstrb=0. On edge with mem_ready: latch mem_rdata into
//    buffer, mem_valid=0 for one cycle, then WRITE.
//   WRITE: mem_valid=1, mem_addr=DST, mem_wdata=buffer, mem_wstrb=4'hf. On mem_ready:
//    SRC+=4, DST+=4, REMAINING-=1, mem_valid=0 for one cycle; REMAINING reaching 0 -> IDLE,
//    done=1, busy=0; else READ.
//  Handshake: addr/wdata/wstrb stable while mem_valid high; mem_valid never dropped before
//   mem_ready; mem_valid low at least one cycle between transactions; mem_ready with
//   mem_valid low ignored.
//  Abort: latched when written; honoured at next beat boundary (after current mem_ready), never
//   mid-transaction. -> IDLE, aborted=1, done=0, REMAINING holds residual.
//  Timeout: wait counter resets per transaction; TIMEOUT_CYCLES cycles without mem_ready ->
//   mem_valid=0, IDLE, error=1.
//  Arithmetic: SRC/DST wrap modulo 2^32 (0xFFFFFFFC+4 = 0). REMAINING is LEN_WIDTH bits,
//   never underflows.
//  Per word: 2 bus transactions + 2 idle cycles; zero-wait memory gives 4 cycles/word.
//  Async reset mid-copy: immediate return to IDLE, mem_valid=0, no status retained.
// TESTING
//  SRC=0x40000000, DST=0x40001000, LENGTH=3, zero-wait mem -> 6 transactions, addrs in order,
//   data copied, done=1 after 12 cycles.
//  LENGTH=0, start -> no mem_valid, STATUS=0x2 next cycle.
//  SRC=0xFFFFFFFC, LENGTH=2 -> second read at 0x00000000.
//  mem_ready withheld, TIMEOUT_CYCLES=16 -> mem_valid drops after 16 cycles, STATUS=0x4.
//  Abort during word 2 of 5, 3-cycle mem latency -> current write completes, REMAINING=3,
//   STATUS=0x8.
//  SRC write and second start while busy -> ignored, original copy completes intact.

Source files
------------

// File: rtl/dma_copy.sv
// Word-copy bus initiator: copies LENGTH words SRC->DST over the native memory bus,
// one read then one write per word, programmed through a zero-wait MMIO target port.
module dma_copy #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned LEN_WIDTH      = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        we,
   input  logic [7:0]  address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_RGAP, S_WRITE, S_WGAP} state_t;

   state_t                 state_q, state_d;
   logic [31:0]            src_q, src_d, dst_q, dst_d, buf_q, buf_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d, rem_q, rem_d;
   logic [TW-1:0]          wait_q, wait_d;
   logic                   done_q, done_d, err_q, err_d, abt_q, abt_d;
   logic                   abort_req_q, abort_req_d;
   logic                   wr_en, idle;

   assign wr_en = cs & we;
   assign idle  = (state_q == S_IDLE);
   assign busy  = ~idle;
   assign ready = cs;

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      buf_d       = buf_q;
      len_d       = len_q;
      rem_d       = rem_q;
      wait_d      = wait_q;
      done_d      = done_q;
      err_d       = err_q;
      abt_d       = abt_q;
      abort_req_d = abort_req_q;

      if (wr_en && idle) begin
         case (address)
            8'h10:   src_d = {write_data[31:2], 2'b00};
            8'h11:   dst_d = {write_data[31:2], 2'b00};
            8'h12:   len_d = write_data[LEN_WIDTH-1:0];
            default: ;
         endcase
      end
      if (wr_en && !idle && address == 8'h08 && write_data[1])
         abort_req_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (wr_en && address == 8'h08 && write_data[0]) begin
               err_d  = 1'b0;
               abt_d  = 1'b0;
               wait_d = '0;
               if (len_q != '0) begin
                  done_d  = 1'b0;
                  rem_d   = len_q;
                  state_d = S_READ;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         S_READ: begin
            if (mem_ready) begin
               buf_d   = mem_rdata;
               state_d = S_RGAP;
            end else if (wait_q == TW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wait_d  = wait_q + TW'(1);
            end
         end
         S_RGAP: begin
            wait_d  = '0;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (mem_ready) begin
               src_d   = src_q + 32'd4;
               dst_d   = dst_q + 32'd4;
               if (rem_q != '0) rem_d = rem_q - LEN_WIDTH'(1);
               state_d = S_WGAP;
            end else if (wait_q == TW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wait_d  = wait_q + TW'(1);
            end
         end
         S_WGAP: begin
            // Word boundary: completion wins over a pending abort on the last word.
            wait_d = '0;
            if (rem_q == '0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (abort_req_d) begin
               abt_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_READ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_IDLE) abort_req_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         buf_q       <= '0;
         len_q       <= '0;
         rem_q       <= '0;
         wait_q      <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         abt_q       <= 1'b0;
         abort_req_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         buf_q       <= buf_d;
         len_q       <= len_d;
         rem_q       <= rem_d;
         wait_q      <= wait_d;
         done_q      <= done_d;
         err_q       <= err_d;
         abt_q       <= abt_d;
         abort_req_q <= abort_req_d;
      end
   end

   always_comb begin
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      if (state_q == S_READ) begin
         mem_valid = 1'b1;
         mem_addr  = src_q;
      end else if (state_q == S_WRITE) begin
         mem_valid = 1'b1;
         mem_addr  = dst_q;
         mem_wdata = buf_q;
         mem_wstrb = 4'hf;
      end
   end

   always_comb begin
      read_data = '0;
      if (cs) begin
         case (address)
            8'h09:   read_data = {28'd0, abt_q, err_q, done_q, busy};
            8'h10:   read_data = src_q;
            8'h11:   read_data = dst_q;
            8'h12:   read_data = 32'(len_q);
            8'h13:   read_data = 32'(rem_q);
            default: read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: register vector table plus hand-written copy, wrap,
// timeout, abort, busy-write and reset sequences against a small bus memory model.
module tb_dma_copy;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cs, we;
   logic [7:0]  address;
   logic [31:0] write_data, read_data;
   logic        ready;
   logic        mem_valid, mem_ready, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   int checks = 0;
   int errors = 0;

   dma_copy #(.TIMEOUT_CYCLES(16), .LEN_WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // memory model: 64 words hashed on addr bit 12 and word offset
   logic [31:0] mem [64];
   int          latency = 0;
   int          lat_cnt = 0;
   logic        hold = 1'b0;

   function automatic int unsigned idx(input logic [31:0] a);
      return int'({a[12], a[6:2]});
   endfunction

   function automatic logic [31:0] init_val(input int unsigned i);
      return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
   endfunction

   assign mem_ready = mem_valid && !hold && (lat_cnt >= latency);
   assign mem_rdata = mem[idx(mem_addr)];

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
   } txn_t;
   txn_t log_q[$];

   always @(posedge clk) begin
      if (mem_valid && !mem_ready) lat_cnt <= lat_cnt + 1;
      else                         lat_cnt <= 0;
      if (mem_valid && mem_ready) begin
         log_q.push_back('{mem_addr, mem_wstrb == 4'hf, (mem_wstrb == 4'hf) ? mem_wdata : mem_rdata});
         if (mem_wstrb == 4'hf) mem[idx(mem_addr)] <= mem_wdata;
      end
   end

   // handshake monitor
   logic        hs_en = 1'b1;
   int          hs_viol = 0;
   logic        pv = 1'b0, pr = 1'b0;
   logic [31:0] pa = '0, pd = '0;
   logic [3:0]  ps = '0;
   always @(posedge clk) begin
      if (hs_en && reset_n) begin
         if (pv && !pr && (!mem_valid || mem_addr !== pa || mem_wdata !== pd || mem_wstrb !== ps))
            hs_viol++;
         if (pv && pr && mem_valid) hs_viol++;
         if (mem_valid && mem_addr[1:0] != 2'b00) hs_viol++;
      end
      pv = mem_valid; pr = mem_ready; pa = mem_addr; pd = mem_wdata; ps = mem_wstrb;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic init_mem();
      for (int unsigned i = 0; i < 64; i++) mem[i] = init_val(i);
      log_q.delete();
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; address = a; write_data = d;
      @(posedge clk);
      #1;
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic peek(input logic [7:0] a, output logic [31:0] d);
      cs = 1'b1; we = 1'b0; address = a;
      #1;
      d = read_data;
      cs = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk);
      peek(a, d);
   endtask

   task automatic wait_idle(input int max_cycles, input string nm);
      int n = 0;
      while (busy && n < max_cycles) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(nm, 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic        cs;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;
   vec_t vt[11];

   logic [31:0] d;
   int          cnt;

   initial begin
      reset_n = 1'b0; cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
      init_mem();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      rd(8'h09, d); chk("rst_status", d, 32'h0);
      rd(8'h13, d); chk("rst_remaining", d, 32'h0);

      vt[0]  = '{1, 1, 8'h10, 32'h12345677, 32'h0,        "wr_src"};
      vt[1]  = '{1, 0, 8'h10, 32'h0,        32'h12345674, "rd_src_aligned"};
      vt[2]  = '{1, 1, 8'h11, 32'hABCDEF03, 32'h0,        "wr_dst"};
      vt[3]  = '{1, 0, 8'h11, 32'h0,        32'hABCDEF00, "rd_dst_aligned"};
      vt[4]  = '{1, 1, 8'h12, 32'h00010007, 32'h0,        "wr_len"};
      vt[5]  = '{1, 0, 8'h12, 32'h0,        32'h00000007, "rd_len_16bit"};
      vt[6]  = '{1, 0, 8'h13, 32'h0,        32'h00000000, "rd_remaining"};
      vt[7]  = '{1, 0, 8'h09, 32'h0,        32'h00000000, "rd_status"};
      vt[8]  = '{1, 0, 8'h08, 32'h0,        32'h00000000, "rd_ctrl_zero"};
      vt[9]  = '{1, 0, 8'h20, 32'h0,        32'h00000000, "rd_unmapped"};
      vt[10] = '{0, 0, 8'h10, 32'h0,        32'h00000000, "rd_cs_low"};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         cs = vt[i].cs; we = vt[i].we; address = vt[i].addr; write_data = vt[i].wdata;
         #1;
         chk({vt[i].name, "_ready"}, 32'(ready), 32'(vt[i].cs));
         if (!vt[i].we) chk(vt[i].name, read_data, vt[i].exp);
         @(posedge clk);
         #1;
         cs = 1'b0; we = 1'b0;
      end

      // 3-word copy, zero-wait memory
      init_mem(); latency = 0;
      wr(8'h10, 32'h40000000); wr(8'h11, 32'h40001000); wr(8'h12, 32'd3);
      wr(8'h08, 32'h1);
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         if (c == 11) chk("copy3_busy_c11", 32'(busy), 32'd1);
      end
      peek(8'h09, d); chk("copy3_status_c12", d, 32'h2);
      chk("copy3_ntxn", 32'(log_q.size()), 32'd6);
      for (int k = 0; k < 6 && k < log_q.size(); k++) begin
         chk("copy3_addr", log_q[k].addr,
             (k % 2 == 0) ? 32'h40000000 + 32'(4 * (k / 2)) : 32'h40001000 + 32'(4 * (k / 2)));
         chk("copy3_dir", 32'(log_q[k].wr), 32'(k % 2));
      end
      for (int unsigned k = 0; k < 3; k++) chk("copy3_data", mem[32 + k], init_val(k));
      rd(8'h13, d); chk("copy3_remaining", d, 32'h0);

      // LENGTH=0
      init_mem();
      wr(8'h12, 32'd0); wr(8'h08, 32'h1);
      peek(8'h09, d); chk("len0_status", d, 32'h2);
      repeat (4) @(posedge clk);
      chk("len0_no_traffic", 32'(log_q.size()), 32'd0);

      // SRC wrap
      init_mem();
      wr(8'h10, 32'hFFFFFFFC); wr(8'h11, 32'h40001000); wr(8'h12, 32'd2);
      wr(8'h08, 32'h1);
      wait_idle(40, "wrap_idle");
      chk("wrap_ntxn", 32'(log_q.size()), 32'd4);
      if (log_q.size() >= 3) chk("wrap_read2_addr", log_q[2].addr, 32'h00000000);
      chk("wrap_data0", mem[32], init_val(63));
      chk("wrap_data1", mem[33], init_val(0));
      rd(8'h10, d); chk("wrap_src_final", d, 32'h00000004);

      // timeout: mem_ready withheld
      init_mem(); hs_en = 1'b0; hold = 1'b1;
      wr(8'h12, 32'd1); wr(8'h08, 32'h1);
      cnt = 0;
      while (mem_valid && cnt < 40) begin
         cnt++;
         @(posedge clk);
         #1;
      end
      chk("timeout_valid_cycles", 32'(cnt), 32'd16);
      rd(8'h09, d); chk("timeout_status", d, 32'h4);
      hold = 1'b0;
      repeat (2) @(posedge clk);
      hs_en = 1'b1;

      // abort during word 2 of 5, 3-cycle latency
      init_mem(); latency = 3;
      wr(8'h10, 32'h40000000); wr(8'h11, 32'h40001000); wr(8'h12, 32'd5);
      wr(8'h08, 32'h1);
      cnt = 0;
      while ((log_q.size() < 2 || !mem_valid) && cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("abort_reached_word2", 32'(log_q.size()), 32'd2);
      wr(8'h08, 32'h2);
      wait_idle(60, "abort_idle");
      chk("abort_ntxn", 32'(log_q.size()), 32'd4);
      if (log_q.size() >= 4) chk("abort_last_write", log_q[3].addr, 32'h40001004);
      rd(8'h13, d); chk("abort_remaining", d, 32'h3);
      rd(8'h09, d); chk("abort_status", d, 32'h8);
      chk("abort_data1", mem[33], init_val(1));

      // writes while busy are ignored
      init_mem(); latency = 1;
      wr(8'h10, 32'h40000000); wr(8'h11, 32'h40001010); wr(8'h12, 32'd4);
      wr(8'h08, 32'h1);
      wr(8'h10, 32'h50000000);
      wr(8'h08, 32'h1);
      wait_idle(80, "busywr_idle");
      chk("busywr_ntxn", 32'(log_q.size()), 32'd8);
      if (log_q.size() >= 7) chk("busywr_read4_addr", log_q[6].addr, 32'h4000000C);
      rd(8'h10, d); chk("busywr_src_final", d, 32'h40000010);
      rd(8'h09, d); chk("busywr_status", d, 32'h2);
      for (int unsigned k = 0; k < 4; k++) chk("busywr_data", mem[36 + k], init_val(k));

      // async reset mid-copy
      init_mem(); latency = 0;
      wr(8'h12, 32'd4); wr(8'h08, 32'h1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      hs_en = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("rstmid_mem_valid", 32'(mem_valid), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      rd(8'h09, d); chk("rstmid_status", d, 32'h0);
      rd(8'h13, d); chk("rstmid_remaining", d, 32'h0);
      rd(8'h10, d); chk("rstmid_src", d, 32'h0);
      repeat (2) @(posedge clk);
      chk("handshake_violations", 32'(hs_viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
